// File: rtl/pc_branch_ctrl.sv
// Program counter and branch/jump control for a single-issue RV32 core.
// The block decodes the branch condition, selects the control-transfer target,
// traps misaligned targets into a sticky HALT state and counts committed
// taken transfers.
module pc_branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_is_branch,
  input  logic        i_is_jal,
  input  logic        i_is_jalr,
  input  logic [2:0]  i_funct3,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_br_un,
  output logic        o_taken,
  output logic        o_misalign,
  output logic        o_halted,
  output logic [15:0] o_taken_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic        misalign_reg;
  logic [15:0] taken_cnt_reg;

  logic        halted;
  logic        br_cond;
  logic        taken;
  logic [31:0] pc_four;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        misalign_now;
  logic        advance;

  // Branch condition from comparator flags; 010/011 are not branch encodings.
  always_comb begin
    br_cond = 1'b0;
    case (i_funct3)
      3'b000:          br_cond = i_br_equal;
      3'b001:          br_cond = ~i_br_equal;
      3'b100, 3'b110:  br_cond = i_br_less;
      3'b101, 3'b111:  br_cond = ~i_br_less;
      default:         br_cond = 1'b0;
    endcase
  end

  // Target selection: JAL wins over JALR, JALR wins over a branch.
  always_comb begin
    jalr_sum = i_rs1_data + i_imm;
    target   = pc_reg + i_imm;
    if (i_is_jal) begin
      target = pc_reg + i_imm;
    end else if (i_is_jalr) begin
      target = jalr_sum & ~32'h1;
    end
  end

  // Transfer decision; a halted core never reports a transfer.
  always_comb begin
    pc_four      = pc_reg + 32'd4;
    taken        = (i_is_jal | i_is_jalr | (i_is_branch & br_cond)) & ~halted;
    misalign_now = taken & (target[1:0] != 2'b00);
    advance      = ~i_stall & (state_reg == ST_RUN);
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: a committed misaligned transfer traps until reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:  if (advance && misalign_now) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    halted = (state_reg == ST_HALT);
  end

  // PC, sticky misalign flag and saturating taken counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_reg        <= RESET_PC;
      misalign_reg  <= 1'b0;
      taken_cnt_reg <= 16'h0000;
    end else if (advance) begin
      if (misalign_now) begin
        // Leave the PC on the faulting instruction for the trap handler.
        misalign_reg <= 1'b1;
      end else begin
        pc_reg <= taken ? target : pc_four;
        if (taken && (taken_cnt_reg != 16'hFFFF)) begin
          taken_cnt_reg <= taken_cnt_reg + 16'd1;
        end
      end
    end
  end

  // Port drive.
  always_comb begin
    o_pc        = pc_reg;
    o_pc_four   = pc_four;
    o_br_un     = ~i_funct3[1];
    o_taken     = taken;
    o_misalign  = misalign_reg;
    o_halted    = halted;
    o_taken_cnt = taken_cnt_reg;
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboard bench for pc_branch_ctrl: stimulus pushes the hand-computed
// expected outputs for each checked cycle; a monitor pops and compares them
// on the falling clock edge.
module tb_pc_branch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic        br_less;
  logic        br_equal;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic        br_un;
  logic        taken;
  logic        misalign;
  logic        halted;
  logic [15:0] taken_cnt;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        taken;
    logic        br_un;
    logic        mis;
    logic        halt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  pc_branch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_stall     (stall),
    .i_is_branch (is_branch),
    .i_is_jal    (is_jal),
    .i_is_jalr   (is_jalr),
    .i_funct3    (funct3),
    .i_br_less   (br_less),
    .i_br_equal  (br_equal),
    .i_imm       (imm),
    .i_rs1_data  (rs1_data),
    .o_pc        (pc),
    .o_pc_four   (pc_four),
    .o_br_un     (br_un),
    .o_taken     (taken),
    .o_misalign  (misalign),
    .o_halted    (halted),
    .o_taken_cnt (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the oldest expectation against the settled outputs.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] exp_four;
      e = sb_q.pop_front();
      exp_four = e.pc + 32'd4;
      n_cmp = n_cmp + 1;
      if (pc !== e.pc || pc_four !== exp_four || taken !== e.taken ||
          br_un !== e.br_un || misalign !== e.mis || halted !== e.halt ||
          taken_cnt !== e.cnt) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got pc=%h pc4=%h tk=%b bu=%b mis=%b hlt=%b cnt=%h; want pc=%h pc4=%h tk=%b bu=%b mis=%b hlt=%b cnt=%h",
                 e.name, pc, pc_four, taken, br_un, misalign, halted, taken_cnt,
                 e.pc, exp_four, e.taken, e.br_un, e.mis, e.halt, e.cnt);
      end else begin
        $display("ok   %s: pc=%h tk=%b bu=%b mis=%b hlt=%b cnt=%h",
                 e.name, pc, taken, br_un, misalign, halted, taken_cnt);
      end
    end
  end

  task automatic drive(input logic rst, input logic stl, input logic br,
                       input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic less, input logic eq,
                       input logic [31:0] im, input logic [31:0] rs1);
    reset     = rst;
    stall     = stl;
    is_branch = br;
    is_jal    = jal;
    is_jalr   = jalr;
    funct3    = f3;
    br_less   = less;
    br_equal  = eq;
    imm       = im;
    rs1_data  = rs1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation for the current cycle, then commit the edge.
  task automatic chk(input string nm, input logic [31:0] e_pc, input logic e_tk,
                     input logic e_bu, input logic e_mis, input logic e_hlt,
                     input logic [15:0] e_cnt);
    exp_t e;
    e.name  = nm;
    e.pc    = e_pc;
    e.taken = e_tk;
    e.br_un = e_bu;
    e.mis   = e_mis;
    e.halt  = e_hlt;
    e.cnt   = e_cnt;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
  endtask

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout; want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    do_reset();

    // Sequential flow after reset.
    chk("rst_pc0", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("seq_pc4", 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("seq_pc8", 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("seq_pcC", 32'hC, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    // Back to pc = 8 for the branch sequence.
    do_reset();
    chk("seq2_pc0", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("seq2_pc4", 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("blt_taken", 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("bgeu_not_taken", 32'h18, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    chk("bne_backward", 32'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 32'h40, 32'h0);
    chk("f3_010_never", 32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h101);
    chk("jalr_101", 32'h18, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2);

    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 32'h8, 32'h200);
    chk("jal_priority", 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h40, 32'h0);
    chk("stall_beq", 32'h108, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h102);
    chk("stall_hold_jalr102", 32'h108, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h4, 32'h0);
    chk("halt_frozen", 32'h108, 1'b0, 1'b1, 1'b1, 1'b1, 16'd4);
    chk("halt_frozen2", 32'h108, 1'b0, 1'b1, 1'b1, 1'b1, 16'd4);

    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h4, 32'h0);
    chk("halt_reset_cycle", 32'h108, 1'b0, 1'b1, 1'b1, 1'b1, 16'd4);

    idle();
    chk("reset_from_halt", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    // Misaligned transfer under stall must not be captured.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h102);
    chk("stall_misaligned", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    idle();
    chk("stall_mis_no_trap", 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    // Counter saturation: 65536 taken JALs of +4 from pc 0.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 65536; i++) begin
      tick();
    end
    chk("sat_reached", 32'h0004_0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    chk("sat_held", 32'h0004_0004, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    chk("jalr_to_top", 32'h0004_0008, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h4, 32'h0);
    chk("jal_wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    idle();
    chk("wrapped_to_zero", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL scoreboard_drain: got %0d pending; want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port i_clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port i_stall  input  1  hold PC and all state this cycle.
REQ-006 SHALL have port i_is_branch  input  1  current instruction is B-type.
REQ-007 SHALL have port i_is_jal  input  1  current instruction is JAL.
REQ-008 SHALL have port i_is_jalr  input  1  current instruction is JALR.
REQ-009 SHALL have port i_funct3  input  3  branch funct3.
REQ-010 SHALL have port i_br_less  input  1  less-than flag from branch comparator.
REQ-011 SHALL have port i_br_equal  input  1  equal flag from branch comparator.
REQ-012 SHALL have port i_imm  input  32  sign-extended immediate.
REQ-013 SHALL have port i_rs1_data  input  32  rs1 value for JALR.
REQ-014 SHALL have port o_pc  output  32  current PC.
REQ-015 SHALL have port o_pc_four  output  32  o_pc + 4, for link write-back.
REQ-016 SHALL have port o_br_un  output  1  comparator mode to branch comparator: 1 = signed, 0 = unsigned.
REQ-017 SHALL have port o_taken  output  1  control transfer taken this cycle.
REQ-018 SHALL have port o_misalign  output  1  sticky misaligned-target flag.
REQ-019 SHALL have port o_halted  output  1  FSM in HALT.
REQ-020 SHALL have port o_taken_cnt  output  16  saturating count of committed taken transfers.

Function
REQ-021 SHALL drive o_br_un = ~i_funct3[1], combinationally (BLT/BGE signed, BLTU/BGEU unsigned, BEQ/BNE don't-care).
REQ-022 SHALL decode the branch condition: 000 equal; 001 ~equal; 100/110 less; 101/111 ~less; 010/011 never taken.
REQ-023 SHALL drive o_taken combinationally = i_is_jal | i_is_jalr | (i_is_branch & condition), forced 0 in HALT.
REQ-024 SHALL compute target = o_pc + i_imm for branch/JAL and (i_rs1_data + i_imm) & ~32'h1 for JALR, all modulo 2^32 (wrap-around is silent).
REQ-025 SHALL give JAL priority over JALR over branch when more than one select is high.
REQ-026 SHALL flag misalignment when o_taken = 1 and target[1:0] != 2'b00.
REQ-027 SHALL use FSM states RUN and HALT; RUN -> HALT on a non-stalled edge with misalignment; HALT exits only on reset.
REQ-028 SHALL update o_pc on each non-stalled RUN edge: target if taken and aligned, else o_pc + 4.
REQ-029 SHALL, on a misaligned edge, keep o_pc at the faulting instruction, set o_misalign = 1, and leave o_taken_cnt unchanged.
REQ-030 SHALL hold o_pc, FSM and counter in HALT regardless of inputs.
REQ-031 SHALL, when i_stall = 1, hold all state with no misalign capture and no count, while o_taken and o_br_un still reflect their inputs.
REQ-032 SHALL increment o_taken_cnt on each non-stalled RUN edge with an aligned taken transfer, saturating at 16'hFFFF.
REQ-033 SHALL make a new PC visible on o_pc exactly one cycle after the deciding edge, so the branch latency is 1 cycle.
REQ-034 SHALL compute o_pc_four = o_pc + 4 combinationally, wrapping 32'hFFFF_FFFC to 32'h0.

Reset
REQ-035 SHALL, on a rising edge with i_reset = 1, set o_pc = RESET_PC, FSM = RUN, o_misalign = 0, o_taken_cnt = 0, o_halted = 0; this overrides stall, HALT and any in-flight transfer.
REQ-036 SHALL take the first normal PC update on the first edge with i_reset = 0.

Verification
REQ-037 SHALL check sequential flow: reset, then 3 idle cycles -> o_pc = 0, 4, 8, C; o_taken = 0.
REQ-038 SHALL check a taken BLT: pc = 8, funct3 = 100, br_less = 1, imm = 32'h10 -> o_br_un = 1, o_taken = 1, next o_pc = 32'h18, o_taken_cnt = 1.
REQ-039 SHALL check a not-taken BGEU: funct3 = 111, br_less = 1 -> o_br_un = 0, o_taken = 0, o_pc advances by 4.
REQ-040 SHALL check JALR alignment: rs1 = 32'h101, imm = 0 -> next o_pc = 32'h100; with rs1 = 32'h102 -> o_misalign = 1, o_halted = 1, o_pc frozen until reset.
REQ-041 SHALL check stall plus reset: i_stall = 1 with a taken BEQ -> o_pc unchanged and count unchanged; i_reset asserted while in HALT -> o_pc = RESET_PC and all flags cleared next cycle.
REQ-042 SHALL check counter saturation and wrap: preload-free run of 65 536 taken JALs with imm = 4 -> o_taken_cnt = 16'hFFFF (held); JAL from pc = 32'hFFFF_FFFC with imm = 4 -> o_pc = 0.
